// File: rtl/mem_stage_pkg.sv
// Shared encodings and byte-lane helpers for the MIPS memory-access stage.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int OFFS_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Half accesses look only at offset bit 1, so an odd half address lands on its natural pair.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [OFFS_W-1:0] off);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << off;
            SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: store_lanes = {4{data[7:0]}};
            SZ_HALF: store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [OFFS_W-1:0] off,
                                                input logic uns, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: load_extend = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: load_extend = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_byte_ram.sv
// DEPTH x 32 data RAM: per-byte write enables, registered read with enable, async active-low clear.
module byte_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_q <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
            // Read port only advances on load completion so the output doubles as the load-result hold register.
            if (i_re) r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: sized loads/stores behind a wait-state FSM that stalls upstream.
// Optional MEM_STAGE_ALIGN_CHECK_EN suppresses misaligned half/word accesses and flags them.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] alu_res,
    input  logic [31:0] rt_data,
    output logic        pc_source,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        stall,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_cnt, w_cnt_nxt;
    logic [AW-1:0]       r_word;
    logic [OFFS_W-1:0]   r_off;
    logic [1:0]          r_size;
    logic                r_uns, r_wr, r_rd;
    logic [31:0]         r_wdata;
    logic [1:0]          r_ld_size;
    logic [OFFS_W-1:0]   r_ld_off;
    logic                r_ld_uns, r_ld_zero, r_read_valid;

    logic                w_idle, w_req, w_stall, w_fire, w_mis, w_re;
    logic [AW-1:0]       w_word;
    logic [OFFS_W-1:0]   w_off;
    logic [1:0]          w_size;
    logic                w_uns, w_wr, w_rd;
    logic [31:0]         w_wdata, w_rdata;
    logic [3:0]          w_we;
    logic                w_unused;

    assign w_idle = (r_state == ST_IDLE);
    assign w_req  = mem_read | mem_write;

    // In IDLE the access is taken straight from the inputs so a zero-wait access can complete on its first edge.
    assign w_word  = w_idle ? alu_res[2 +: AW]           : r_word;
    assign w_off   = w_idle ? alu_res[OFFS_W-1:0]        : r_off;
    assign w_size  = w_idle ? mem_size                   : r_size;
    assign w_uns   = w_idle ? mem_unsigned               : r_uns;
    assign w_wr    = w_idle ? mem_write                  : r_wr;
    assign w_rd    = w_idle ? (mem_read & ~mem_write)    : r_rd;
    assign w_wdata = w_idle ? rt_data                    : r_wdata;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign w_mis = ((w_size == SZ_HALF) && w_off[0]) || (w_size[1] && (w_off != 2'b00));
`else
    assign w_mis = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_stall = 1'b1;
                    if (WAIT_STATES > 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                w_stall = 1'b1;
                if (r_cnt == 3'd0) w_state_nxt = ST_DONE;
                else               w_cnt_nxt   = r_cnt - 3'd1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_fire = (w_state_nxt == ST_DONE);
    assign w_we   = (w_fire && w_wr && !w_mis) ? lane_mask(w_size, w_off) : 4'b0000;
    assign w_re   = w_fire & w_rd & ~w_mis;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 3'd0;
            r_read_valid <= 1'b0;
            r_ld_size    <= SZ_WORD;
            r_ld_off     <= '0;
            r_ld_uns     <= 1'b0;
            r_ld_zero    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_read_valid <= w_re;
            if (w_fire && w_rd) begin
                r_ld_size <= w_size;
                r_ld_off  <= w_off;
                r_ld_uns  <= w_uns;
                r_ld_zero <= w_mis;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_idle && w_req) begin
            r_word  <= alu_res[2 +: AW];
            r_off   <= alu_res[OFFS_W-1:0];
            r_size  <= mem_size;
            r_uns   <= mem_unsigned;
            r_wr    <= mem_write;
            r_rd    <= mem_read & ~mem_write;
            r_wdata <= rt_data;
        end
    end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic r_misalign;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_misalign <= 1'b0;
        else        r_misalign <= w_fire & w_mis;
    end
    assign misalign = r_misalign;
`else
    assign misalign = 1'b0;
`endif

    byte_ram #(.DEPTH(DEPTH), .AW(AW)) data_memory (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_word),
        .i_wdata (store_lanes(w_size, w_wdata)),
        .o_rdata (w_rdata)
    );

    assign read_data  = r_ld_zero ? 32'h0 : load_extend(r_ld_size, r_ld_off, r_ld_uns, w_rdata);
    assign read_valid = r_read_valid;
    assign stall      = reset & w_stall;
    assign pc_source  = reset & branch & alu_zero & ~w_stall;
    assign w_unused   = &{1'b0, alu_res};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (DEPTH=16, WAIT_STATES=1), honours MEM_STAGE_ALIGN_CHECK_EN.
module tb_mem_stage;

    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch, alu_zero, mem_write, mem_read, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] alu_res, rt_data;
    logic        pc_source, read_valid, stall, misalign;
    logic [31:0] read_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(16), .WAIT_STATES(WS)) dut (
        .clk          (clk),
        .reset        (reset),
        .branch       (branch),
        .alu_zero     (alu_zero),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .alu_res      (alu_res),
        .rt_data      (rt_data),
        .pc_source    (pc_source),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .stall        (stall),
        .misalign     (misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_write = 1'b0; mem_read = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
        alu_res = 32'h0; rt_data = 32'h0; branch = 1'b0; alu_zero = 1'b0;
    endtask

    // One full access: checks stall across IDLE/WAIT, then the DONE-cycle outputs.
    task automatic access(input logic wr, input logic rd, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_rd, input logic exp_mis, input string tag);
        @(negedge clk);
        mem_write = wr; mem_read = rd; mem_size = sz; mem_unsigned = uns;
        alu_res = addr; rt_data = data;
        for (int c = 0; c <= WS; c++) begin
            if (c > 0) @(negedge clk);
            #1 check({tag, " stall"}, {31'h0, stall}, 32'h1);
        end
        @(negedge clk);
        #1;
        check({tag, " done stall"}, {31'h0, stall}, 32'h0);
        check({tag, " read_valid"}, {31'h0, read_valid}, {31'h0, rd & ~wr & ~exp_mis});
        check({tag, " misalign"}, {31'h0, misalign}, {31'h0, exp_mis});
        if (rd && !wr) check({tag, " read_data"}, read_data, exp_rd);
        mem_write = 1'b0; mem_read = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        // Outputs gated while reset is held, even with a request and a taken branch present.
        branch = 1'b1; alu_zero = 1'b1; mem_read = 1'b1;
        #12;
        check("rst stall", {31'h0, stall}, 32'h0);
        check("rst pc_source", {31'h0, pc_source}, 32'h0);
        check("rst read_data", read_data, 32'h0);
        check("rst read_valid", {31'h0, read_valid}, 32'h0);
        check("rst misalign", {31'h0, misalign}, 32'h0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;

        access(1, 0, 2'b10, 0, 32'h8, 32'hDEADBEEF, 32'h0, 0, "st w8");
        access(0, 1, 2'b10, 0, 32'h8, 32'h0, 32'hDEADBEEF, 0, "ld w8");

        access(1, 0, 2'b00, 0, 32'h5, 32'h00000080, 32'h0, 0, "st b5");
        access(0, 1, 2'b00, 0, 32'h5, 32'h0, 32'hFFFFFF80, 0, "ld b5 s");
        access(0, 1, 2'b00, 1, 32'h5, 32'h0, 32'h00000080, 0, "ld b5 u");
        access(0, 1, 2'b10, 0, 32'h4, 32'h0, 32'h00008000, 0, "ld w4");

        access(1, 0, 2'b10, 0, 32'h0, 32'hAABBCCDD, 32'h0, 0, "st w0");
        access(1, 0, 2'b01, 0, 32'h2, 32'h00001234, 32'h0, 0, "st h2");
        access(0, 1, 2'b10, 0, 32'h0, 32'h0, 32'h1234CCDD, 0, "ld w0 merge");
        access(0, 1, 2'b01, 0, 32'h0, 32'h0, 32'hFFFFCCDD, 0, "ld h0 s");
        access(0, 1, 2'b00, 1, 32'h1, 32'h0, 32'h000000CC, 0, "ld b1 u");
        access(0, 1, 2'b11, 1, 32'h0, 32'h0, 32'h1234CCDD, 0, "ld sz11");

`ifdef MEM_STAGE_ALIGN_CHECK_EN
        access(0, 1, 2'b10, 0, 32'h6, 32'h0, 32'h0, 1, "ld w6 mis");
        access(0, 1, 2'b01, 1, 32'h3, 32'h0, 32'h0, 1, "ld h3 mis");
        access(1, 0, 2'b10, 0, 32'h9, 32'hFFFFFFFF, 32'h0, 1, "st w9 mis");
        access(0, 1, 2'b10, 0, 32'h8, 32'h0, 32'hDEADBEEF, 0, "ld w8 kept");
`else
        access(0, 1, 2'b10, 0, 32'h6, 32'h0, 32'h00008000, 0, "ld w6 align");
        access(0, 1, 2'b01, 1, 32'h3, 32'h0, 32'h00001234, 0, "ld h3 align");
`endif

        access(1, 0, 2'b10, 0, 32'h40, 32'h00000055, 32'h0, 0, "st w40");
        access(0, 1, 2'b10, 0, 32'h0, 32'h0, 32'h00000055, 0, "ld w0 wrap");

        // Load result holds after the valid pulse and across a store.
        @(negedge clk);
        #1;
        check("hold valid", {31'h0, read_valid}, 32'h0);
        check("hold data", read_data, 32'h00000055);
        access(1, 1, 2'b10, 0, 32'h10, 32'h00000077, 32'h0, 0, "rw w10");
        check("hold data2", read_data, 32'h00000055);
        access(0, 1, 2'b10, 0, 32'h10, 32'h0, 32'h00000077, 0, "ld w10");

        // Abort a store mid-WAIT with reset.
        @(negedge clk);
        mem_write = 1'b1; mem_size = 2'b10; alu_res = 32'hC; rt_data = 32'h13572468;
        #1 check("abort stall0", {31'h0, stall}, 32'h1);
        @(negedge clk);
        #1 check("abort stall1", {31'h0, stall}, 32'h1);
        reset = 1'b0;
        #1 check("abort rst stall", {31'h0, stall}, 32'h0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        #1 check("abort idle stall", {31'h0, stall}, 32'h0);
        access(0, 1, 2'b10, 0, 32'hC, 32'h0, 32'h0, 0, "ld wC abort");

        // Branch resolution with no memory op.
        @(negedge clk);
        branch = 1'b1; alu_zero = 1'b1;
        #1;
        check("br taken pc", {31'h0, pc_source}, 32'h1);
        check("br taken stall", {31'h0, stall}, 32'h0);
        alu_zero = 1'b0;
        #1 check("br not taken pc", {31'h0, pc_source}, 32'h0);
        alu_zero = 1'b1; mem_read = 1'b1;
        #1 check("br gated by stall", {31'h0, pc_source}, 32'h0);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised memory-access pipeline stage for the single-issue MIPS datapath, replacing the fixed single-cycle word-only memory stage. Supports byte, halfword and word loads and stores with sign or zero extension. Adds a configurable-latency data memory behind a small FSM that stalls the pipeline until each access completes. Resolves the branch (`pc_source`) only when the stage is free to advance.

## Interface
- `DEPTH`, 16: data memory size in 32-bit words; power of two, ≥ 2.
- `WAIT_STATES`, 1: extra memory cycles per access, 0..7.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `branch` in 1: branch instruction in stage.
- `alu_zero` in 1: ALU zero flag.
- `mem_write` in 1: store request.
- `mem_read` in 1: load request.
- `mem_size` in 2: access size; 00 byte, 01 half, 10 word, 11 treated as word.
- `mem_unsigned` in 1: loads zero-extend when 1, sign-extend when 0.
- `alu_res` in 32: byte address.
- `rt_data` in 32: store data, right-justified.
- `pc_source` out 1: `branch & alu_zero & ~stall`.
- `read_data` out 32: extended load result.
- `read_valid` out 1: load result valid this cycle.
- `stall` out 1: freeze upstream pipeline registers.
- `misalign` out 1: misaligned access flag. Only driven when the alignment-check macro is defined (see Configuration).

## Operation
- FSM states: IDLE, WAIT, DONE.
  - IDLE with `mem_read|mem_write` → latch address, size, unsigned flag, store data and op; `stall`=1.
    - `WAIT_STATES`>0: go to WAIT.
    - `WAIT_STATES`=0: go to DONE.
  - WAIT: counter runs from `WAIT_STATES`-1 down to 0; `stall`=1; at 0 go to DONE.
  - DONE: `stall`=0. Unconditionally returns to IDLE. Requests seen in DONE are ignored; they belong to the completing instruction.
- `mem_read` and `mem_write` both high: treated as store; no load, `read_valid` stays 0.
- Word index = `alu_res[2 +: log2(DEPTH)]`. Upper bits are ignored, so addresses wrap modulo `DEPTH` words. Byte lane = `alu_res[1:0]`.
- Store lanes:
  - byte: `rt_data[7:0]` to lane `alu_res[1:0]`.
  - half: `rt_data[15:0]` to lanes {1,0} if `alu_res[1]`=0, else {3,2}.
  - word: all lanes.
  - Unselected bytes are unchanged.
- Load: select the byte or half the same way, then extend to 32 bits per `mem_unsigned`. Word loads ignore `mem_unsigned`.
- Upstream holds all inputs stable while `stall`=1; the stage uses only latched values after IDLE.

## Timing
- Reset values: state IDLE, counter 0, `read_data` 0, `read_valid` 0, `misalign` 0, all memory words 0.
  - While `reset` is low: `stall` and `pc_source` are forced to 0.
- The memory write and the `read_data` register update both occur on the edge that enters DONE.
- An access presented in cycle 0 has `stall` high for cycles 0..`WAIT_STATES`. DONE is cycle `WAIT_STATES`+1, with `read_valid`=1 for a load.
- Non-memory instructions: no stall, zero latency.
- `read_valid` is a one-cycle pulse in DONE. `read_data` holds its value until the next load completes.
- `pc_source` is low whenever `stall` is high. A branch never coincides with a memory op, so in practice `pc_source` = `branch & alu_zero` for branch instructions.
- Reset asserted mid-access (WAIT or before the DONE edge): the access is aborted, memory is unmodified, and the FSM returns to IDLE.
- Back-to-back accesses: the next request is sampled in the IDLE cycle after DONE. Throughput is one access per `WAIT_STATES`+2 cycles.

## Configuration
- `MEM_STAGE_ALIGN_CHECK_EN` defined:
  - A half access with `alu_res[0]`=1, or a word access with `alu_res[1:0]`≠0, is suppressed: no write, `read_data` loaded with 0, `read_valid`=0.
  - `misalign` pulses 1 in DONE. Stall timing is unchanged.
- Not defined:
  - `misalign` is tied 0.
  - Low address bits are ignored to force natural alignment: half ignores bit 0, word ignores bits 1:0.

## Structure
- Package `mem_stage_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - FSM state encoding;
  - byte-offset width constant (2);
  - lane-mask and extend helper functions.
- One sub-module, `byte_ram`: `DEPTH`×32 RAM with 4-bit byte-enable write, registered read, asynchronous active-low clear. Instantiated as `data_memory`.

## Test plan
- Reset, then store word 0xDEADBEEF at 0x8 and load word 0x8 with `WAIT_STATES`=1 → `stall` high for 2 cycles, `read_valid` in cycle 2, `read_data`=0xDEADBEEF.
- Store byte 0x80 at 0x5, then load byte at 0x5 with `mem_unsigned`=0 → 0xFFFFFF80; with `mem_unsigned`=1 → 0x00000080; word at 0x4 = 0x00008000.
- Store half 0x1234 at 0x2 over word 0xAABBCCDD at 0x0 → word load of 0x0 returns 0x1234CCDD.
- `DEPTH`=16, store word 0x55 at 0x40, load 0x0 → 0x55 (wrap-around).
- Reset pulsed low during WAIT of a store to 0xC → FSM IDLE, `stall` 0, subsequent load of 0xC returns 0.
- Alignment and branch:
  - With `MEM_STAGE_ALIGN_CHECK_EN`, word load at 0x6 → `misalign`=1 in DONE, `read_data`=0.
  - `branch`=`alu_zero`=1 with no memory op → `pc_source`=1 immediately, `stall`=0.
